// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed N-digit common-anode 7-segment driver with frame-synchronous double buffering
module seg7_scan_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int DEAD_CYC   = 2,
   parameter bit HEX_EN     = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic                      blank_lz,
   input  logic                      enable,
   output logic [6:0]                seg,
   output logic                      dp_n,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      frame_start
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);

   logic [CW-1:0]           cnt, cnt_n;
   logic [IW-1:0]           idx, idx_n;
   logic [4*NUM_DIGITS-1:0] sh_v, act_v, act_v_n;
   logic [NUM_DIGITS-1:0]   sh_dp, act_dp, act_dp_n;
   logic                    tick, wrap, dead;
   logic [3:0]              code;
   logic                    dsel, lz, zero;

   function automatic logic [6:0] dec(input logic [3:0] c);
      if (!HEX_EN && c > 4'd9) return 7'b1111111;
      case (c)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         4'hF: return 7'b0001110;
      endcase
   endfunction

   // Outputs are decoded from the next-state view so the registered pins line up with frame_start.
   assign tick     = cnt == CW'(SCAN_DIV - 1);
   assign wrap     = tick && idx == IW'(NUM_DIGITS - 1);
   assign cnt_n    = tick ? '0 : cnt + 1'b1;
   assign idx_n    = wrap ? '0 : idx + IW'(tick);
   assign act_v_n  = wrap ? sh_v : act_v;
   assign act_dp_n = wrap ? sh_dp : act_dp;
   assign dead     = int'(cnt_n) < DEAD_CYC;

   // Select the scanned digit and decide whether it falls in a run of leading zeros.
   always_comb begin
      code = '0;
      dsel = 1'b0;
      lz   = 1'b0;
      zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero = zero && act_v_n[4*i +: 4] == 4'd0;
         if (idx_n == IW'(i)) begin
            code = act_v_n[4*i +: 4];
            dsel = act_dp_n[i];
            lz   = zero && i != 0;
         end
      end
   end

   // Scan counters, shadow/active buffers and registered display pins.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt         <= '0;
         idx         <= '0;
         sh_v        <= '0;
         sh_dp       <= '0;
         act_v       <= '0;
         act_dp      <= '0;
         an          <= '1;
         seg         <= '1;
         dp_n        <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         cnt         <= cnt_n;
         idx         <= idx_n;
         if (load) begin
            sh_v  <= value;
            sh_dp <= dp;
         end
         act_v       <= act_v_n;
         act_dp      <= act_dp_n;
         an          <= (!enable || dead) ? '1 : ~(NUM_DIGITS'(1) << idx_n);
         seg         <= (!enable || (blank_lz && lz)) ? 7'b1111111 : dec(code);
         dp_n        <= !(enable && dsel);
         frame_start <= wrap;
      end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: scoreboard bench for the 4-digit scan driver (SCAN_DIV=4, DEAD_CYC=1), hex and BCD builds
module tb_seg7_scan_mux;
   logic        clk = 1'b0;
   logic        rst_n, load, blank_lz, enable;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [6:0]  seg, seg_b;
   logic        dp_n, dpn_b, fs, fs_b;
   logic [3:0]  an, an_b;
   int          n_tests = 0;
   int          n_fail  = 0;

   typedef struct packed {
      logic       fs;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dpn;
      logic [6:0] bseg;
   } exp_t;
   exp_t q[$];

   logic [6:0] lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   seg7_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .HEX_EN(1'b1)) u_hex (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp), .blank_lz(blank_lz),
      .enable(enable), .seg(seg), .dp_n(dp_n), .an(an), .frame_start(fs));

   seg7_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .HEX_EN(1'b0)) u_bcd (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp), .blank_lz(blank_lz),
      .enable(enable), .seg(seg_b), .dp_n(dpn_b), .an(an_b), .frame_start(fs_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Expected pins for one whole frame, k = cycle within the frame starting at frame_start.
   task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic blz,
                             input logic [15:0] drv, input logic fs0);
      for (int k = 0; k < 16; k++) begin
         int         s  = k / 4;
         logic       en = (k == 0) ? 1'b1 : drv[k-1];
         logic [3:0] c  = 4'((v >> (4*s)) & 16'hF);
         logic       bl = blz && s != 0 && (v >> (4*s)) == 16'd0;
         exp_t       e;
         e.fs   = (k == 0) ? fs0 : 1'b0;
         e.an   = (!en || k % 4 == 0) ? 4'hF : ~(4'b0001 << s);
         e.seg  = (!en || bl) ? 7'h7F : lut[c];
         e.dpn  = !(en && d[s]);
         e.bseg = (!en || bl || c > 4'd9) ? 7'h7F : lut[c];
         q.push_back(e);
      end
   endtask

   task automatic check_frame(input string name, input logic [15:0] drv);
      int k = 16 - q.size();
      while (q.size() > 0) begin
         exp_t e = q.pop_front();
         chk($sformatf("%s k%0d {fs,an,seg,dp_n}", name, k), {fs, an, seg, dp_n}, {e.fs, e.an, e.seg, e.dpn});
         chk($sformatf("%s k%0d bcd_seg", name, k), seg_b, e.bseg);
         enable = drv[k];
         k++;
         @(negedge clk);
      end
      enable = 1'b1;
   endtask

   task automatic wait_frame();
      for (int i = 0; i < 40; i++) begin
         if (fs) return;
         @(negedge clk);
      end
      chk("frame_start timeout", 0, 1);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp    = d;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   logic [15:0] pv [6] = '{16'h1234, 16'hABCF, 16'h9087, 16'hDE56, 16'h0050, 16'h0000};
   logic [3:0]  pd [6] = '{4'b0000, 4'b0000, 4'b1010, 4'b0101, 4'b0100, 4'b0000};
   logic        pb [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      rst_n = 1'b0; load = 1'b0; value = '0; dp = '0; blank_lz = 1'b0; enable = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset {fs,an,seg,dp_n}", {fs, an, seg, dp_n}, {1'b0, 4'hF, 7'h7F, 1'b1});
      rst_n = 1'b1;
      @(negedge clk);
      push_frame(16'h0, 4'h0, 1'b0, 16'hFFFF, 1'b0);
      void'(q.pop_front());
      check_frame("first_frame", 16'hFFFF);
      for (int p = 0; p < 6; p++) begin
         wait_frame();
         blank_lz = pb[p];
         do_load(pv[p], pd[p]);
         wait_frame();
         push_frame(pv[p], pd[p], pb[p], 16'hFFFF, 1'b1);
         check_frame($sformatf("pat%0d", p), 16'hFFFF);
      end
      blank_lz = 1'b0;
      wait_frame();
      do_load(16'h1111, 4'h0);
      repeat (4) @(negedge clk);
      do_load(16'h2222, 4'h0);
      wait_frame();
      push_frame(16'h2222, 4'h0, 1'b0, 16'hFFFF, 1'b1);
      check_frame("tear_last_wins", 16'hFFFF);
      do_load(16'h3333, 4'h1);
      repeat (14) @(negedge clk);
      do_load(16'h4444, 4'h2);
      push_frame(16'h3333, 4'h1, 1'b0, 16'hFFFF, 1'b1);
      check_frame("tear_coincident_old", 16'hFFFF);
      push_frame(16'h4444, 4'h2, 1'b0, 16'hFFFF, 1'b1);
      check_frame("tear_coincident_new", 16'hFFFF);
      push_frame(16'h4444, 4'h2, 1'b0, 16'hC00F, 1'b1);
      check_frame("enable_gap", 16'hC00F);
      push_frame(16'h4444, 4'h2, 1'b0, 16'hFFFF, 1'b1);
      check_frame("after_enable", 16'hFFFF);
      repeat (6) @(negedge clk);
      chk("pre_reset an", an, 4'b1101);
      #2 rst_n = 1'b0;
      #1 chk("async_reset {fs,an,seg,dp_n}", {fs, an, seg, dp_n}, {1'b0, 4'hF, 7'h7F, 1'b1});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_frame(16'h0, 4'h0, 1'b0, 16'hFFFF, 1'b0);
      void'(q.pop_front());
      check_frame("post_reset", 16'hFFFF);
      push_frame(16'h0, 4'h0, 1'b0, 16'hFFFF, 1'b1);
      check_frame("post_reset_wrap", 16'hFFFF);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
